// File: rtl/elbeth_csr_arbiter_pkg.sv
// Shared definitions for the CSR access-port arbiter: FSM states and CSR command codes.
package elbeth_csr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_PEND,
    ARB_RESP
  } arb_state_t;

  // bit2 = enable, bits1:0 select the write flavour (00 = plain read)
  localparam logic [2:0] CSR_READ  = 3'b100;
  localparam logic [2:0] CSR_WRITE = 3'b101;
  localparam logic [2:0] CSR_SET   = 3'b110;
  localparam logic [2:0] CSR_CLEAR = 3'b111;

  function automatic logic csr_cmd_active(input logic [2:0] cmd);
    return cmd[2];
  endfunction

endpackage

// File: rtl/elbeth_starve_counter.sv
// Saturating wait counter with synchronous clear and an at-limit flag.
module elbeth_starve_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam int unsigned W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] count;

  assign at_limit = (count == W'(LIMIT));

  // Count enabled cycles, clear on request, stick at LIMIT
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !at_limit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/elbeth_csr_arbiter.sv
// Shares the CSR register-file port between core CSR instructions (priority)
// and a single-outstanding host/debug request inserted into idle core cycles.
module elbeth_csr_arbiter
  import elbeth_csr_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  core_csr_cmd,
  input  logic [11:0] core_csr_addr,
  input  logic [31:0] core_csr_wdata,
  input  logic        core_exception,
  input  logic        core_eret,
  output logic [31:0] core_csr_rdata,
  output logic        core_illegal_access,
  output logic        core_stall,
  input  logic        host_req_valid,
  output logic        host_req_ready,
  input  logic        host_req_write,
  input  logic [11:0] host_req_addr,
  input  logic [31:0] host_req_wdata,
  output logic        host_resp_valid,
  input  logic        host_resp_ready,
  output logic [31:0] host_resp_rdata,
  output logic        host_resp_error,
  output logic [2:0]  csr_cmd,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic        csr_illegal_access
);

  arb_state_t  state;
  logic        hold_write;
  logic [11:0] hold_addr;
  logic [31:0] hold_wdata;
  logic        at_limit;
  logic        slot;
  logic        grant;

  assign host_req_ready = (state == ARB_IDLE);
  assign core_stall     = (state == ARB_PEND) && at_limit;
  // A stalled core's own command does not block the slot; exception/eret always do
  assign slot           = !core_exception && !core_eret &&
                          (!csr_cmd_active(core_csr_cmd) || core_stall);
  assign grant          = (state == ARB_PEND) && slot;

  elbeth_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .clr     (host_req_ready && host_req_valid),
    .en      ((state == ARB_PEND) && !slot),
    .at_limit(at_limit)
  );

  // Port mux: host owns the CSR port only in the grant cycle
  always_comb begin
    csr_cmd             = core_csr_cmd;
    csr_addr            = core_csr_addr;
    csr_wdata           = core_csr_wdata;
    core_csr_rdata      = csr_rdata;
    core_illegal_access = csr_illegal_access;
    if (grant) begin
      csr_cmd             = hold_write ? CSR_WRITE : CSR_READ;
      csr_addr            = hold_addr;
      csr_wdata           = hold_wdata;
      core_csr_rdata      = '0;
      core_illegal_access = 1'b0;
    end
  end

  // Host request FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ARB_IDLE;
      host_resp_valid <= 1'b0;
      host_resp_rdata <= '0;
      host_resp_error <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (host_req_valid) begin
            hold_write <= host_req_write;
            hold_addr  <= host_req_addr;
            hold_wdata <= host_req_wdata;
            state      <= ARB_PEND;
          end
        end
        ARB_PEND: begin
          if (slot) begin
            host_resp_rdata <= csr_rdata;
            host_resp_error <= csr_illegal_access;
            host_resp_valid <= 1'b1;
            state           <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (host_resp_ready) begin
            host_resp_valid <= 1'b0;
            state           <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/elbeth_csr_arbiter.md
Name: elbeth_csr_arbiter

Overview:
Shares the single CSR register file access port between the core pipeline (CSR instructions) and a host/debug request channel.
- Core traffic always has priority.
- Host requests are serialized and inserted into idle core CSR cycles.
- A starvation counter forces a one-slot pipeline stall if the host waits too long.
- Sits between the decode/execute stage, the host interface and elbeth_csr_register.

Parameters:
STARVE_LIMIT, 16, PEND cycles without a slot before core_stall is asserted (0 = stall in the first PEND cycle).

Ports:
clk  in  1  clock
rst  in  1  reset
core_csr_cmd  in  3  core CSR command; bit2 = enable, bits1:0 != 0 = write
core_csr_addr  in  12  core CSR address
core_csr_wdata  in  32  core CSR write data
core_exception  in  1  exception being taken this cycle
core_eret  in  1  eret being executed this cycle
core_csr_rdata  out  32  read data returned to core
core_illegal_access  out  1  illegal-access flag returned to core
core_stall  out  1  freezes the pipeline for one host slot
host_req_valid  in  1  host request valid
host_req_ready  out  1  arbiter accepts a host request
host_req_write  in  1  1 = write, 0 = read
host_req_addr  in  12  host CSR address
host_req_wdata  in  32  host write data
host_resp_valid  out  1  response valid
host_resp_ready  in  1  host accepts the response
host_resp_rdata  out  32  read data (old value on writes)
host_resp_error  out  1  CSR block flagged illegal access
csr_cmd  out  3  to CSR block
csr_addr  out  12  to CSR block
csr_wdata  out  32  to CSR block
csr_rdata  in  32  from CSR block
csr_illegal_access  in  1  from CSR block

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset values: state IDLE, starve counter 0, host_resp_valid 0, host_resp_rdata 0, host_resp_error 0, core_stall 0.
- Reset during PEND or RESP discards the captured request; no response is produced.
- FSM states: IDLE, PEND, RESP.
- IDLE:
  - host_req_ready = 1.
  - On host_req_valid & host_req_ready, capture write/addr/wdata into holding registers, clear the counter, go to PEND.
  - No same-cycle bypass.
- PEND:
  - host_req_ready = 0.
  - slot = !core_exception & !core_eret & (!core_csr_cmd[2] | core_stall).
  - On slot, grant: csr_cmd = host_req_write ? `CSR_WRITE : 3'b100; csr_addr/csr_wdata come from the holding registers.
  - In the grant cycle, csr_rdata → host_resp_rdata and csr_illegal_access → host_resp_error are registered; go to RESP.
  - With no slot, the counter increments, saturating at STARVE_LIMIT.
  - Counter width is $clog2(STARVE_LIMIT+1), minimum 1.
- core_stall = (state == PEND) & (counter == STARVE_LIMIT). It is combinational and high through the grant cycle.
- Exception and eret always win over the host, even while core_stall = 1. In that case the grant is deferred and the counter holds.
- While core_stall = 1, the stalled core's CSR command is ignored. The core re-issues it after the stall.
- RESP:
  - host_resp_valid = 1; rdata and error are held stable until host_resp_ready.
  - Then go to IDLE. The next request is accepted in the following cycle, at the earliest.
- Non-grant cycles: csr_* = core_* pass-through, core_csr_rdata = csr_rdata, core_illegal_access = csr_illegal_access.
- Grant cycles: core_csr_rdata = 0 and core_illegal_access = 0.
- Latency: request accepted at cycle t → grant at t+1 at earliest → host_resp_valid at t+2.
- Only one host request is outstanding at a time. There is no queueing.

Decomposition:
- Shared definitions in elbeth_definitions.v: FSM state encodings ARB_IDLE/ARB_PEND/ARB_RESP, the CSR_READ value 3'b100, and the existing `CSR_WRITE/`CSR_SET/`CSR_CLEAR.
- Optional sub-module elbeth_starve_counter: a saturating counter with clear, enable and an at_limit flag.
- The mux and FSM stay in the top module.

Test Plan:
- Core idle, host read of addr 0x340 (mscratch = 0x12345678) accepted at t → grant at t+1, host_resp_valid at t+2 with rdata 0x12345678 and error 0.
- Core issues back-to-back CSR cmds for 20 cycles, STARVE_LIMIT = 16 → core_stall rises 16 cycles after PEND entry, host granted that same cycle, core_stall low the next cycle.
- Host write 0xCAFEF00D to 0x340 while core_exception pulses on the would-be slot cycle → grant slips one cycle, resp rdata = old value, a later read returns 0xCAFEF00D.
- Host access to an undefined address 0x7FF → host_resp_error = 1, rdata = 0; core_illegal_access stays 0.
- host_resp_ready held low 5 cycles → resp_valid/rdata stable, host_req_ready = 0; ready high → IDLE next cycle.
- rst asserted in PEND → next cycle IDLE, host_req_ready = 1, no host_resp_valid, core_stall = 0.
